alu16_seq: RTL and testbench
============================

Name: alu16_seq

Overview:
Two-cycle sequencer that runs the 16-bit arithmetic ops (ADD HL,rr; ADD SP,e8 / LD HL,SP+e8; INC rr; DEC rr) through the shared 8-bit ALU, low byte first, then high byte.
Sits between the CPU control unit and the single ALU instance. While it holds the ALU it asserts alu_own, and the CPU datapath mux uses that signal to select this block's ALU inputs.
Every op is an ADD on the low byte followed by an ADC on the high byte. No subtract path is used.

Parameters:
ALU_OP_ADD, 5'b00000, ALU opcode for the low-byte cycle
ALU_OP_ADC, 5'b00001, ALU opcode for the high-byte cycle

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock domain; reset is synchronous and active-high
start  in  1  request; accepted only in IDLE
op  in  2  0=ADD_HL, 1=ADD_SP, 2=INC16, 3=DEC16
a16  in  16  first operand (HL, SP or rr)
b16  in  16  second operand; ADD_SP uses b16[7:0] as signed e8; ignored for INC16/DEC16
flags_in  in  4  current F, {Z,N,H,C}
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse; result16/flags_out valid in the same cycle
result16  out  16  registered result
flags_out  out  4  registered flags {Z,N,H,C}
alu_own  out  1  high in LO and HI states
alu_a  out  8  to ALU alu_a
alu_b  out  8  to ALU alu_b
alu_op  out  5  to ALU alu_op
alu_flags_in  out  4  to ALU alu_flags_in
alu_result  in  8  from ALU
alu_flags_out  in  4  from ALU

Behaviour:
- Reset: state=IDLE; busy, done, alu_own=0; result16, flags_out=0; all alu_* outputs=0; latched operands cleared.
- Reset mid-operation: abort to IDLE on the next edge, no done pulse, result16/flags_out zeroed.
- States: IDLE -> LO -> HI -> DONE -> IDLE.
  - In IDLE, start=1 latches op, a16, b16 and flags_in, then moves to LO.
  - LO, HI and DONE advance unconditionally.
- Start handling: start is ignored when busy=1, including in DONE. A new start is accepted no earlier than the first cycle back in IDLE.
- Latency: accept at edge N; done=1 during cycle N+3. The next accept is possible at the edge that ends cycle N+4.
- Byte operands (bL = low-byte operand, bH = high-byte operand):
  - ADD_HL: bL=b16[7:0], bH=b16[15:8]
  - ADD_SP: bL=e8, bH = e8[7] ? 8'hFF : 8'h00
  - INC16: bL=8'h01, bH=8'h00
  - DEC16: bL=8'hFF, bH=8'hFF (two's-complement add of -1)
- LO cycle: alu_a=a16[7:0], alu_b=bL, alu_op=ALU_OP_ADD, alu_flags_in=latched flags. Capture alu_result into the low byte, and capture alu_flags_out H and C into low_h/low_c.
- HI cycle: alu_a=a16[15:8], alu_b=bH, alu_op=ALU_OP_ADC, alu_flags_in={3'b0, low_c}. Capture alu_result into the high byte, and capture alu_flags_out H and C into hi_h/hi_c.
- Flags written at the HI->DONE edge:
  - ADD_HL: {Z_in, 0, hi_h, hi_c}
  - ADD_SP: {0, 0, low_h, low_c}; Z stays 0 even when the result is 0
  - INC16/DEC16: flags_in unchanged
- Outside LO/HI: alu_own=0 and all alu_* outputs are 0.
- Wrap-around: 16-bit results wrap mod 2^16 (0xFFFF+1 -> 0x0000; 0x0000-1 -> 0xFFFF).
- result16/flags_out hold their value after DONE until the next completion or reset.

Optional Feature:
Macro ALU16_SEQ_FAST_INCDEC_EN.
- Defined: INC16/DEC16 use a local 16-bit incrementer/decrementer.
  - Sequence is IDLE -> DONE, so done is asserted in cycle N+1.
  - alu_own is never asserted for these ops.
  - ADD_HL and ADD_SP are unchanged.
- Undefined: every op takes the LO/HI path with 3-cycle latency, as described above.

Decomposition:
- Shared package: op encodings (OP16_ADD_HL..OP16_DEC16), the state encoding (IDLE/LO/HI/DONE), the flag bit indices F_Z=3, F_N=2, F_H=1, F_C=0, and the ALU opcodes ADD/ADC.
- No sub-module: the byte-operand select is a small combinational case inside the block. The ALU remains external and shared.

Test Plan:
1. ADD_HL: a16=0x0FFF, b16=0x0001, flags_in=4'b1000 -> result16=0x1000, flags_out=4'b1010. done is high exactly 3 cycles after accept, and alu_own is high for exactly 2 cycles.
2. ADD_HL: a16=0xFFFF, b16=0x0001, flags_in=4'b0000 -> result16=0x0000, flags_out=4'b0011 (Z preserved as 0).
3. ADD_SP: a16=0x00FF, e8=0x01 -> result16=0x0100, flags_out=4'b0011. Then a16=0x0000, e8=0xFF -> result16=0xFFFF, flags_out=4'b0000.
4. INC16 on 0xFFFF -> 0x0000; DEC16 on 0x0000 -> 0xFFFF. flags_in=4'b1010 is returned unchanged in both cases. With ALU16_SEQ_FAST_INCDEC_EN, done comes 1 cycle after accept and alu_own stays 0.
5. Hold start=1 continuously with changing a16 -> operands are latched only at accept, and back-to-back ops complete every 4 cycles. Check the ALU port values cycle-by-cycle, in particular alu_flags_in[0] equals low_c during HI.
6. Assert rst during HI -> IDLE on the next cycle, no done pulse, and every output is 0.

Source files
------------

// File: rtl/alu16_seq_pkg.sv
// Shared definitions for the 16-bit ALU sequencer: op encodings, FSM state
// encoding, flag bit positions and the two ALU opcodes it drives.
package alu16_seq_pkg;

    typedef enum logic [1:0] {
        OP16_ADD_HL = 2'd0,
        OP16_ADD_SP = 2'd1,
        OP16_INC16  = 2'd2,
        OP16_DEC16  = 2'd3
    } op16_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int F_Z = 3;
    localparam int F_N = 2;
    localparam int F_H = 1;
    localparam int F_C = 0;

    localparam logic [4:0] ALU_OP_ADD = 5'b00000;
    localparam logic [4:0] ALU_OP_ADC = 5'b00001;

    // Byte operands fed to the ALU: {high-byte operand, low-byte operand}.
    // Every op is expressed as an add, so DEC16 adds 0xFFFF and ADD_SP adds
    // the sign-extended e8.
    function automatic logic [15:0] byte_operands(input op16_e op, input logic [15:0] b16);
        logic [15:0] ops;
        ops = 16'h0000;
        case (op)
            OP16_ADD_HL: ops = b16;
            OP16_ADD_SP: ops = {(b16[7] ? 8'hFF : 8'h00), b16[7:0]};
            OP16_INC16:  ops = 16'h0001;
            OP16_DEC16:  ops = 16'hFFFF;
            default:     ops = 16'h0000;
        endcase
        return ops;
    endfunction

endpackage

// File: rtl/alu16_seq.sv
// Two-cycle sequencer running 16-bit ADD/INC/DEC through the shared 8-bit ALU,
// low byte (ADD) then high byte (ADC).
// Build option: ALU16_SEQ_FAST_INCDEC_EN - when defined, INC16/DEC16 use a
// local 16-bit incrementer/decrementer and go IDLE -> DONE without the ALU.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; operands latched on accept
// LO      | ALU owned, low byte ADD, capture low byte and low H/C
// HI      | ALU owned, high byte ADC with low carry, write result/flags
// DONE    | done pulse, result16/flags_out valid
module alu16_seq
    import alu16_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] a16,
    input  logic [15:0] b16,
    input  logic [3:0]  flags_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] result16,
    output logic [3:0]  flags_out,
    output logic        alu_own,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [4:0]  alu_op,
    output logic [3:0]  alu_flags_in,
    input  logic [7:0]  alu_result,
    input  logic [3:0]  alu_flags_out
);

    state_e      state_q,  state_d;
    op16_e       op_q,     op_d;
    logic [15:0] a_q,      a_d;
    logic [15:0] b_q,      b_d;
    logic [3:0]  f_q,      f_d;
    logic [7:0]  res_lo_q, res_lo_d;
    logic        low_h_q,  low_h_d;
    logic        low_c_q,  low_c_d;
    logic [15:0] result_q, result_d;
    logic [3:0]  flags_q,  flags_d;

    logic [15:0] ops;
    logic        hi_h;
    logic        hi_c;
    logic        unused_alu_zn;

    assign ops           = byte_operands(op_q, b_q);
    assign hi_h          = alu_flags_out[F_H];
    assign hi_c          = alu_flags_out[F_C];
    // Z and N from the ALU are never used: Z of a 16-bit add is not a byte Z.
    assign unused_alu_zn = ^{alu_flags_out[F_Z], alu_flags_out[F_N]};

    // Next-state, operand latch and result/flag capture.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        f_d      = f_q;
        res_lo_d = res_lo_q;
        low_h_d  = low_h_q;
        low_c_d  = low_c_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = op16_e'(op);
                    a_d     = a16;
                    b_d     = b16;
                    f_d     = flags_in;
                    state_d = ST_LO;
`ifdef ALU16_SEQ_FAST_INCDEC_EN
                    if (op16_e'(op) == OP16_INC16) begin
                        result_d = a16 + 16'd1;
                        flags_d  = flags_in;
                        state_d  = ST_DONE;
                    end else if (op16_e'(op) == OP16_DEC16) begin
                        result_d = a16 - 16'd1;
                        flags_d  = flags_in;
                        state_d  = ST_DONE;
                    end
`endif
                end
            end
            ST_LO: begin
                res_lo_d = alu_result;
                low_h_d  = alu_flags_out[F_H];
                low_c_d  = alu_flags_out[F_C];
                state_d  = ST_HI;
            end
            ST_HI: begin
                result_d = {alu_result, res_lo_q};
                case (op_q)
                    OP16_ADD_HL: flags_d = {f_q[F_Z], 1'b0, hi_h, hi_c};
                    OP16_ADD_SP: flags_d = {2'b00, low_h_q, low_c_q};
                    default:     flags_d = f_q;
                endcase
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP16_ADD_HL;
            a_q      <= '0;
            b_q      <= '0;
            f_q      <= '0;
            res_lo_q <= '0;
            low_h_q  <= 1'b0;
            low_c_q  <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            f_q      <= f_d;
            res_lo_q <= res_lo_d;
            low_h_q  <= low_h_d;
            low_c_q  <= low_c_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    // ALU drive, decoded purely from registered state and latched operands.
    always_comb begin
        alu_own      = 1'b0;
        alu_a        = 8'h00;
        alu_b        = 8'h00;
        alu_op       = 5'b00000;
        alu_flags_in = 4'b0000;
        case (state_q)
            ST_LO: begin
                alu_own      = 1'b1;
                alu_a        = a_q[7:0];
                alu_b        = ops[7:0];
                alu_op       = ALU_OP_ADD;
                alu_flags_in = f_q;
            end
            ST_HI: begin
                alu_own      = 1'b1;
                alu_a        = a_q[15:8];
                alu_b        = ops[15:8];
                alu_op       = ALU_OP_ADC;
                alu_flags_in = {3'b000, low_c_q};
            end
            default: begin
                alu_own      = 1'b0;
            end
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign result16  = result_q;
    assign flags_out = flags_q;

endmodule

// File: tb/tb_alu16_seq.sv
// Self-checking bench for alu16_seq with a behavioural 8-bit ALU attached.
module tb_alu16_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a16;
    logic [15:0] b16;
    logic [3:0]  flags_in;
    logic        busy;
    logic        done;
    logic [15:0] result16;
    logic [3:0]  flags_out;
    logic        alu_own;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [4:0]  alu_op;
    logic [3:0]  alu_flags_in;
    logic [7:0]  alu_result;
    logic [3:0]  alu_flags_out;

    int checks = 0;
    int errors = 0;

    alu16_seq dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a16(a16), .b16(b16),
        .flags_in(flags_in), .busy(busy), .done(done), .result16(result16),
        .flags_out(flags_out), .alu_own(alu_own), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_flags_in(alu_flags_in), .alu_result(alu_result),
        .alu_flags_out(alu_flags_out)
    );

    always #5 clk = ~clk;

    // External 8-bit ALU: opcode 0 = ADD, opcode 1 = ADC (carry in from flags bit 0).
    always_comb begin
        int cin, s, hs;
        cin = (alu_op == 5'b00001) ? int'(alu_flags_in[0]) : 0;
        s   = int'(alu_a) + int'(alu_b) + cin;
        hs  = int'(alu_a[3:0]) + int'(alu_b[3:0]) + cin;
        alu_result    = s[7:0];
        alu_flags_out = {(s[7:0] == 8'h00), 1'b0, (hs > 15), (s > 255)};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: a 16-bit add of the operand implied by the op, flags from bit carries.
    function automatic logic [19:0] model(input logic [1:0] o, input logic [15:0] a,
                                          input logic [15:0] b, input logic [3:0] f);
        int opd, ia, sum;
        logic [3:0] fl;
        ia = int'(a);
        case (o)
            2'd0:    opd = int'(b);
            2'd1:    opd = b[7] ? int'(b[7:0]) + 32'hFF00 : int'(b[7:0]);
            2'd2:    opd = 1;
            default: opd = 65535;
        endcase
        sum = (ia + opd) % 65536;
        case (o)
            2'd0:    fl = {f[3], 1'b0, ((ia % 4096) + (opd % 4096)) > 4095, (ia + opd) > 65535};
            2'd1:    fl = {2'b00, ((ia % 16) + (opd % 16)) > 15, ((ia % 256) + (opd % 256)) > 255};
            default: fl = f;
        endcase
        return {sum[15:0], fl};
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] f, output logic [15:0] res, output logic [3:0] flg);
        int lat, own, exp_lat, exp_own;
        logic [7:0] bl, bh;
        logic lc;
        bit fast;
        fast = 0;
`ifdef ALU16_SEQ_FAST_INCDEC_EN
        fast = (o >= 2'd2);
`endif
        exp_lat = fast ? 1 : 3;
        exp_own = fast ? 0 : 2;
        case (o)
            2'd0:    begin bl = b[7:0]; bh = b[15:8]; end
            2'd1:    begin bl = b[7:0]; bh = b[7] ? 8'hFF : 8'h00; end
            2'd2:    begin bl = 8'h01; bh = 8'h00; end
            default: begin bl = 8'hFF; bh = 8'hFF; end
        endcase
        lc = (int'(a[7:0]) + int'(bl)) > 255;
        @(negedge clk);
        chk("idle_before_start", {31'd0, busy}, 32'd0);
        start = 1'b1; op = o; a16 = a; b16 = b; flags_in = f;
        @(negedge clk);
        start = 1'b0; op = o + 2'd1; a16 = ~a; b16 = ~b; flags_in = ~f;
        lat = 0; own = 0;
        for (int k = 1; k <= 8; k++) begin
            if (alu_own) own++;
            if (!fast && k == 1)
                chk("alu_lo_ports", {alu_own, alu_a, alu_b, alu_op, alu_flags_in},
                    {1'b1, a[7:0], bl, 5'b00000, f});
            if (!fast && k == 2)
                chk("alu_hi_ports", {alu_own, alu_a, alu_b, alu_op, alu_flags_in},
                    {1'b1, a[15:8], bh, 5'b00001, 3'b000, lc});
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        chk("done_latency", lat, exp_lat);
        chk("alu_own_cycles", own, exp_own);
        res = result16;
        flg = flags_out;
        @(negedge clk);
        chk("idle_after_done", {30'd0, busy, done}, 32'd0);
        chk("result_hold", {12'd0, result16, flags_out}, {12'd0, res, flg});
    endtask

    typedef struct {
        logic [1:0]  o;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  f;
        logic [15:0] exp_res;
        logic [3:0]  exp_flg;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [15:0] res;
        logic [3:0]  flg;
        logic [19:0] m;
        logic [15:0] q[$];
        int last_done, cyc, dcount;

        vecs[0] = '{2'd0, 16'h0FFF, 16'h0001, 4'b1000, 16'h1000, 4'b1010};
        vecs[1] = '{2'd0, 16'hFFFF, 16'h0001, 4'b0000, 16'h0000, 4'b0011};
        vecs[2] = '{2'd1, 16'h00FF, 16'h0001, 4'b0000, 16'h0100, 4'b0011};
        vecs[3] = '{2'd1, 16'h0000, 16'h00FF, 4'b1111, 16'hFFFF, 4'b0000};
        vecs[4] = '{2'd2, 16'hFFFF, 16'h1234, 4'b1010, 16'h0000, 4'b1010};
        vecs[5] = '{2'd3, 16'h0000, 16'h1234, 4'b1010, 16'hFFFF, 4'b1010};

        rst = 1'b1; start = 1'b0; op = 2'd0; a16 = 16'h0; b16 = 16'h0; flags_in = 4'h0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy, done, alu_own, alu_a, alu_b, alu_op, alu_flags_in},
            32'd0);
        chk("reset_result", {12'd0, result16, flags_out}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", {29'd0, busy, done, alu_own}, 32'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].f, res, flg);
            chk($sformatf("vec%0d_result", i), {16'd0, res}, {16'd0, vecs[i].exp_res});
            chk($sformatf("vec%0d_flags", i), {28'd0, flg}, {28'd0, vecs[i].exp_flg});
        end

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  o;
            logic [15:0] a, b;
            logic [3:0]  f;
            o = 2'($urandom_range(0, 3));
            a = 16'($urandom);
            b = 16'($urandom);
            f = 4'($urandom);
            run_op(o, a, b, f, res, flg);
            m = model(o, a, b, f);
            chk($sformatf("rand%0d_op%0d_result", i, o), {16'd0, res}, {16'd0, m[19:4]});
            chk($sformatf("rand%0d_op%0d_flags", i, o), {28'd0, flg}, {28'd0, m[3:0]});
        end

        // start held high with a16 changing every cycle: only accepted values count.
        op = 2'd0; b16 = 16'h0101; flags_in = 4'h0;
        last_done = -1; dcount = 0;
        for (cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (alu_own && alu_op == 5'b00000 && q.size() > 0)
                chk("hold_lo_alu_a", {24'd0, alu_a}, {24'd0, q[0][7:0]});
            if (alu_own && alu_op == 5'b00001 && q.size() > 0)
                chk("hold_hi_carry", {31'd0, alu_flags_in[0]},
                    {31'd0, (int'(q[0][7:0]) + 1) > 255});
            if (done) begin
                if (q.size() == 0) begin
                    chk("hold_unexpected_done", 32'd1, 32'd0);
                end else begin
                    m = model(2'd0, q[0], 16'h0101, 4'h0);
                    chk("hold_result", {16'd0, result16}, {16'd0, m[19:4]});
                    void'(q.pop_front());
                end
                if (last_done >= 0) chk("hold_done_spacing", cyc - last_done, 4);
                last_done = cyc;
                dcount++;
            end
            start = 1'b1;
            a16 = 16'($urandom);
            if (!busy) q.push_back(a16);
        end
        start = 1'b0;
        chk("hold_done_count", dcount >= 8, 1);
        repeat (6) @(negedge clk);

        // Reset asserted while in HI.
        run_op(2'd0, 16'h1234, 16'h1111, 4'h0, res, flg);
        chk("pre_reset_result", {16'd0, res}, 32'h2345);
        @(negedge clk);
        start = 1'b1; op = 2'd0; a16 = 16'h4321; b16 = 16'h0101; flags_in = 4'h8;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("in_hi_before_reset", {alu_own, alu_op}, {1'b1, 5'b00001});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_outputs", {busy, done, alu_own, alu_a, alu_b, alu_op, alu_flags_in},
            32'd0);
        chk("abort_result", {12'd0, result16, flags_out}, 32'd0);
        dcount = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        chk("no_done_after_abort", dcount, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
